// File: rtl/piso_if.sv
// Handshake/bus bundle between the pixel fetch side and the serialiser.
// The dblEn pixel-doubling control exists only when PISO_PIXDOUBLE_EN is defined.
interface piso_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] parIn;
    logic             loadStb;
    logic             loadReady;
    logic             shiftEn;
`ifdef PISO_PIXDOUBLE_EN
    logic             dblEn;
`endif
    logic             out;
    logic             outValid;
    logic             underrun;

`ifdef PISO_PIXDOUBLE_EN
    modport master (output parIn, loadStb, shiftEn, dblEn,
                    input  loadReady, out, outValid, underrun);
    modport slave  (input  parIn, loadStb, shiftEn, dblEn,
                    output loadReady, out, outValid, underrun);
`else
    modport master (output parIn, loadStb, shiftEn,
                    input  loadReady, out, outValid, underrun);
    modport slave  (input  parIn, loadStb, shiftEn,
                    output loadReady, out, outValid, underrun);
`endif
endinterface

// File: rtl/piso_serializer.sv
// Double-buffered parallel-in/serial-out pixel serialiser: a holding register
// queues the next word so words stream gap-free. Optional macro PISO_PIXDOUBLE_EN adds dblEn.
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic   clk,
    input logic   nReset,
    piso_if.slave bus
);
    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   sreg, sreg_nx;
    logic [WIDTH-1:0]   hold, hold_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               hold_full, hold_full_nx;
    logic               underrun_q, underrun_nx;
    logic               advance;
`ifdef PISO_PIXDOUBLE_EN
    logic               phase, phase_nx;
`endif

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
        else           return {1'b0, v[WIDTH-1:1]};
    endfunction

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // With doubling, only every second qualified edge moves to the next bit.
`ifdef PISO_PIXDOUBLE_EN
    assign advance = bus.shiftEn & (~bus.dblEn | phase);
`else
    assign advance = bus.shiftEn;
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            sreg       <= '0;
            hold       <= '0;
            cnt        <= '0;
            hold_full  <= 1'b0;
            underrun_q <= 1'b0;
`ifdef PISO_PIXDOUBLE_EN
            phase      <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            sreg       <= sreg_nx;
            hold       <= hold_nx;
            cnt        <= cnt_nx;
            hold_full  <= hold_full_nx;
            underrun_q <= underrun_nx;
`ifdef PISO_PIXDOUBLE_EN
            phase      <= phase_nx;
`endif
        end
    end

    always_comb begin
        state_nx     = state;
        sreg_nx      = sreg;
        hold_nx      = hold;
        cnt_nx       = cnt;
        hold_full_nx = hold_full;
        underrun_nx  = 1'b0;
`ifdef PISO_PIXDOUBLE_EN
        phase_nx     = phase;
`endif
        case (state)
            S_IDLE: begin
                if (hold_full && bus.shiftEn) begin
                    sreg_nx      = hold;
                    cnt_nx       = '0;
                    hold_full_nx = 1'b0;
                    state_nx     = S_ACTIVE;
`ifdef PISO_PIXDOUBLE_EN
                    phase_nx     = 1'b0;
`endif
                end
            end
            S_ACTIVE: begin
`ifdef PISO_PIXDOUBLE_EN
                if (bus.shiftEn) phase_nx = bus.dblEn & ~phase;
`endif
                if (advance) begin
                    if (cnt != LAST) begin
                        sreg_nx = shift_word(sreg);
                        cnt_nx  = cnt + 1'b1;
                    end else if (hold_full) begin
                        sreg_nx      = hold;
                        cnt_nx       = '0;
                        hold_full_nx = 1'b0;
                    end else begin
                        state_nx    = S_IDLE;
                        underrun_nx = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // A transfer needs hold_full=1, so it can never coincide with an accepted load.
        if (bus.loadStb && !hold_full) begin
            hold_nx      = bus.parIn;
            hold_full_nx = 1'b1;
        end
    end

    assign bus.loadReady = ~hold_full;
    assign bus.outValid  = (state == S_ACTIVE);
    assign bus.out       = (state == S_ACTIVE) ? head_bit(sreg) : IDLE_LEVEL;
    assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: lane 0 is MSB-first/idle-low, lane 1 LSB-first/idle-high,
// both driven by the same stimulus and checked every cycle against a bit-queue model.
module tb_piso_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         nReset = 1'b0;
    logic [W-1:0] par_in = '0;
    logic         load_stb = 1'b0;
    logic         shift_en = 1'b0;
    logic         dbl_en = 1'b0;

    logic dut_out [2];
    logic dut_val [2];
    logic dut_rdy [2];
    logic dut_und [2];
    logic exp_out [2];
    logic exp_val [2];
    logic exp_rdy [2];
    logic exp_und [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        piso_if #(.WIDTH(W)) bus ();

        assign bus.parIn   = par_in;
        assign bus.loadStb = load_stb;
        assign bus.shiftEn = shift_en;
`ifdef PISO_PIXDOUBLE_EN
        assign bus.dblEn   = dbl_en;
`endif

        piso_serializer #(
            .WIDTH     (W),
            .MSB_FIRST (g == 0),
            .IDLE_LEVEL(g == 1)
        ) dut (
            .clk   (clk),
            .nReset(nReset),
            .bus   (bus)
        );

        assign dut_out[g] = bus.out;
        assign dut_val[g] = bus.outValid;
        assign dut_rdy[g] = bus.loadReady;
        assign dut_und[g] = bus.underrun;

        // Model: queue of pending output bits, front is the bit on the wire.
        bit           q[$];
        logic [W-1:0] m_hold = '0;
        bit           m_full = 1'b0;
        bit           m_und  = 1'b0;
        bit           m_rdy_pre;
        bit           m_xfer;
        logic         m_o = (g == 1);
        logic         m_v = 1'b0;

        always @(posedge clk or negedge nReset) begin
            if (!nReset) begin
                q.delete();
                m_full = 1'b0;
                m_und  = 1'b0;
                m_hold = '0;
            end else begin
                m_rdy_pre = !m_full;
                m_und     = 1'b0;
                m_xfer    = 1'b0;
                if (shift_en) begin
                    if (q.size() == 0) begin
                        m_xfer = m_full;
                    end else begin
                        void'(q.pop_front());
                        if (q.size() == 0) begin
                            if (m_full) m_xfer = 1'b1;
                            else        m_und  = 1'b1;
                        end
                    end
                end
                if (m_xfer) begin
                    for (int i = 0; i < W; i++) begin
                        q.push_back((g == 0) ? m_hold[W-1-i] : m_hold[i]);
                        if (dbl_en) q.push_back((g == 0) ? m_hold[W-1-i] : m_hold[i]);
                    end
                    m_full = 1'b0;
                end
                if (load_stb && m_rdy_pre) begin
                    m_hold = par_in;
                    m_full = 1'b1;
                end
            end
            m_v = (q.size() != 0);
            m_o = m_v ? q[0] : (g == 1);
        end

        assign exp_out[g] = m_o;
        assign exp_val[g] = m_v;
        assign exp_rdy[g] = !m_full;
        assign exp_und[g] = m_und;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                check($sformatf("lane%0d out", g),       dut_out[g], exp_out[g]);
                check($sformatf("lane%0d outValid", g),  dut_val[g], exp_val[g]);
                check($sformatf("lane%0d loadReady", g), dut_rdy[g], exp_rdy[g]);
                check($sformatf("lane%0d underrun", g),  dut_und[g], exp_und[g]);
            end
        end
    end

    // Load a word at this negedge, then capture n bits per lane plus the end-of-word state.
    task automatic stream(input logic [W-1:0] w, input int n,
                          output logic [15:0] v0, output logic [15:0] v1,
                          output logic all_val, output logic any_und,
                          output logic und_end, output logic val_end);
        v0 = '0; v1 = '0; all_val = 1'b1; any_und = 1'b0;
        par_in   = w;
        load_stb = 1'b1;
        @(negedge clk);
        load_stb = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v0[n-1-i] = dut_out[0];
            v1[n-1-i] = dut_out[1];
            all_val   = all_val & dut_val[0] & dut_val[1];
            any_und   = any_und | dut_und[0] | dut_und[1];
        end
        @(negedge clk);
        und_end = dut_und[0];
        val_end = dut_val[0];
    endtask

    logic [15:0] v0, v1;
    logic        all_val, any_und, und_end, val_end;
    logic [15:0] o1;

    initial begin
        repeat (3) @(negedge clk);
        check("reset out lane0", dut_out[0], 1'b0);
        check("reset out lane1", dut_out[1], 1'b1);
        check("reset outValid", dut_val[0], 1'b0);
        check("reset loadReady", dut_rdy[0], 1'b1);
        check("reset underrun", dut_und[0], 1'b0);
        chk_en = 1'b1;
        #2 nReset = 1'b1;
        @(negedge clk);

        // Single word A5, continuous shifting
        shift_en = 1'b1;
        stream(8'hA5, 8, v0, v1, all_val, any_und, und_end, val_end);
        check("A5 bits lane0", v0[7:0], 8'hA5);
        check("A5 bits lane1", v1[7:0], 8'hA5);
        check("A5 valid", all_val, 1'b1);
        check("A5 no early underrun", any_und, 1'b0);
        check("A5 underrun pulse", und_end, 1'b1);
        check("A5 idle after", val_end, 1'b0);
        @(negedge clk);
        check("A5 underrun one cycle", dut_und[0], 1'b0);

        // Back-to-back FF then 00
        par_in   = 8'hFF;
        load_stb = 1'b1;
        @(negedge clk);
        load_stb = 1'b0;
        check("FF busy", dut_rdy[0], 1'b0);
        @(negedge clk);
        check("FF ready after start", dut_rdy[0], 1'b1);
        v0 = '0; all_val = 1'b1; any_und = 1'b0;
        v0[15]   = dut_out[0];
        par_in   = 8'h00;
        load_stb = 1'b1;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            load_stb  = 1'b0;
            v0[15-i]  = dut_out[0];
            all_val   = all_val & dut_val[0] & dut_val[1];
            any_und   = any_und | dut_und[0] | dut_und[1];
        end
        check("FF00 bits", v0, 16'hFF00);
        check("FF00 contiguous", all_val, 1'b1);
        check("FF00 no mid underrun", any_und, 1'b0);
        @(negedge clk);
        check("FF00 underrun", dut_und[0], 1'b1);

        // LSB-first 01 with gated shifting; second load while busy is ignored
        shift_en = 1'b0;
        par_in   = 8'h01;
        load_stb = 1'b1;
        @(negedge clk);
        par_in   = 8'hFF;
        @(negedge clk);
        check("01 ignored load ready", dut_rdy[1], 1'b0);
        load_stb = 1'b0;
        o1 = '0; all_val = 1'b1;
        for (int i = 0; i < 17; i++) begin
            shift_en = (i % 2 == 0);
            @(negedge clk);
            if (i < 16) begin
                o1[15-i] = dut_out[1];
                all_val  = all_val & dut_val[1];
            end
        end
        check("01 lane1 bits", o1, 16'hC000);
        check("01 lane1 valid", all_val, 1'b1);
        check("01 underrun", dut_und[1], 1'b1);
        shift_en = 1'b1;
        repeat (3) @(negedge clk);
        check("01 ignored word absent", dut_val[1], 1'b0);

        // Reset at bit 3 with a word queued
        par_in   = 8'hA5;
        load_stb = 1'b1;
        @(negedge clk);
        load_stb = 1'b0;
        @(negedge clk);
        par_in   = 8'h3C;
        load_stb = 1'b1;
        @(negedge clk);
        load_stb = 1'b0;
        repeat (2) @(negedge clk);
        #2 nReset = 1'b0;
        #1;
        check("async rst out lane0", dut_out[0], 1'b0);
        check("async rst out lane1", dut_out[1], 1'b1);
        check("async rst outValid", dut_val[0], 1'b0);
        check("async rst loadReady", dut_rdy[0], 1'b1);
        @(negedge clk);
        #2 nReset = 1'b1;
        @(negedge clk);
        check("queued word lost", dut_val[0], 1'b0);
        stream(8'hC3, 8, v0, v1, all_val, any_und, und_end, val_end);
        check("post-reset C3 lane0", v0[7:0], 8'hC3);
        check("post-reset C3 lane1", v1[7:0], 8'hC3);
        check("post-reset underrun", und_end, 1'b1);

`ifdef PISO_PIXDOUBLE_EN
        dbl_en = 1'b1;
        stream(8'hA5, 16, v0, v1, all_val, any_und, und_end, val_end);
        check("dbl A5 lane0", v0, 16'hCC33);
        check("dbl A5 lane1", v1, 16'hCC33);
        check("dbl valid", all_val, 1'b1);
        check("dbl underrun", und_end, 1'b1);
        dbl_en = 1'b0;
        stream(8'hA5, 8, v0, v1, all_val, any_und, und_end, val_end);
        check("dbl off A5 lane0", v0[7:0], 8'hA5);
        check("dbl off underrun", und_end, 1'b1);
`endif

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
